// File: rtl/summator_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// summator_seq_ctrl_if
// Board-side and summator-side signals of the summator sequencing controller.
//   btn_add, btn_clr : raw, bouncy, active-high buttons
//   sw               : 4-bit operand from the switches
//   sum_a, sum_b     : operands presented to the 4-bit summator
//   sum_s            : 5-bit summator result (combinational from sum_a/sum_b)
//   acc              : 8-bit accumulator, drives the LEDs
//   ovf              : sticky 8-bit overflow flag
//   busy             : high while an add is in progress
// The slave modport is the controller; the master modport is its environment
// (board plus summator).
// ---------------------------------------------------------------------------
interface summator_seq_ctrl_if;
    logic       btn_add;
    logic       btn_clr;
    logic [3:0] sw;
    logic [3:0] sum_a;
    logic [3:0] sum_b;
    logic [4:0] sum_s;
    logic [7:0] acc;
    logic       ovf;
    logic       busy;

    modport slave (
        input  btn_add, btn_clr, sw, sum_s,
        output sum_a, sum_b, acc, ovf, busy
    );

    modport master (
        output btn_add, btn_clr, sw, sum_s,
        input  sum_a, sum_b, acc, ovf, busy
    );
endinterface

// File: rtl/summator_seq_ctrl.sv
// ---------------------------------------------------------------------------
// summator_seq_ctrl
// Turns a 4-bit summator into an 8-bit accumulator. Each debounced ADD press
// adds the switch operand in two passes through the shared adder: low nibble,
// then high nibble plus carry. A debounced CLEAR press zeroes the accumulator
// and the overflow flag, aborting any add in flight.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous, active-low reset
//   bus   : summator_seq_ctrl_if.slave (buttons, switches, summator, LEDs)
// Parameter:
//   DB_CNT : consecutive stable cycles before a debounced level changes (>=1)
// ---------------------------------------------------------------------------
module summator_seq_ctrl #(
    parameter int DB_CNT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    summator_seq_ctrl_if.slave  bus
);
    localparam int              CW       = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CNT - 1);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    // Bit 0 is the ADD button, bit 1 the CLEAR button.
    logic [1:0]    raw;
    logic [1:0]    sync0;
    logic [1:0]    sync1;
    logic [1:0]    db;
    logic [1:0]    db_d;
    logic [1:0]    pulse;
    logic [CW-1:0] cnt [2];

    logic          add_p;
    logic          clr_p;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    op_reg;
    logic          carry;
    logic [7:0]    acc;
    logic          ovf;

    assign raw   = {bus.btn_clr, bus.btn_add};
    assign add_p = pulse[0];
    assign clr_p = pulse[1];

    // Button front end: 2-flop synchronizer, debounce counter, and a
    // registered rising-edge pulse of the debounced level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
            db    <= '0;
            db_d  <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            db_d  <= db;
            pulse <= db & ~db_d;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] != db[i]) begin
                    // The DB_CNT-th consecutive mismatching cycle commits the new level.
                    if (cnt[i] == CNT_LAST) begin
                        db[i]  <= sync1[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and summator operand decode; clear overrides everything.
    always_comb begin
        state_nx  = state;
        bus.sum_a = 4'd0;
        bus.sum_b = 4'd0;
        bus.busy  = 1'b0;
        case (state)
            IDLE: begin
                if (add_p) begin
                    state_nx = LO;
                end
            end
            LO: begin
                bus.sum_a = acc[3:0];
                bus.sum_b = op_reg;
                bus.busy  = 1'b1;
                state_nx  = HI;
            end
            HI: begin
                bus.sum_a = acc[7:4];
                bus.sum_b = {3'b000, carry};
                bus.busy  = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (clr_p) begin
            state_nx = IDLE;
        end
    end

    // Accumulator datapath: each pass writes back one nibble of the sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= 8'd0;
            ovf    <= 1'b0;
            carry  <= 1'b0;
            op_reg <= 4'd0;
        end else if (clr_p) begin
            acc   <= 8'd0;
            ovf   <= 1'b0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (add_p) begin
                        op_reg <= bus.sw;
                    end
                end
                LO: begin
                    acc[3:0] <= bus.sum_s[3:0];
                    carry    <= bus.sum_s[4];
                end
                HI: begin
                    acc[7:4] <= bus.sum_s[3:0];
                    if (bus.sum_s[4]) begin
                        ovf <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.acc = acc;
    assign bus.ovf = ovf;
endmodule
